bus_sync: RTL and testbench
===========================

BUS_SYNC -- requirements
Module: bus_sync

Interface
REQ-001 Parameter BUS_WIDTH, default 8: width of the data bus carried across the clock domain.
REQ-002 Parameter NUM_STAGES, default 2: depth of the enable synchroniser chain; legal range 2..4.
REQ-003 Parameter EDGE_MODE, default 0: 0 = rising-edge level mode; 1 = toggle mode (any edge of bus_enable is one event).
REQ-004 Parameter CNT_WIDTH, default 4: width of the event counter.
REQ-005 Port clk, input, 1 bit: destination-domain clock; the block has only this one clock.
REQ-006 Port rst, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-007 Port unsync_bus, input, BUS_WIDTH bits: source-domain data, asynchronous to clk.
REQ-008 Port bus_enable, input, 1 bit: source-domain qualifier for unsync_bus, asynchronous to clk.
REQ-009 Port sync_bus, output, BUS_WIDTH bits: registered copy of unsync_bus, captured on each detected event.
REQ-010 Port enable_pulse, output, 1 bit: registered, single-cycle strobe that marks a new sync_bus value.
REQ-011 Port event_cnt, output, CNT_WIDTH bits: registered count of detected events.

Function
REQ-012 The enable chain is s[0..NUM_STAGES-1], updated on every rising clk edge: s[0] <= bus_enable; s[i] <= s[i-1].
REQ-013 The history flop prev takes s[NUM_STAGES-1] on every rising clk edge.
REQ-014 In EDGE_MODE 0, the event signal is the combinational term s[NUM_STAGES-1] & ~prev.
REQ-015 In EDGE_MODE 1, the event signal is the combinational term s[NUM_STAGES-1] ^ prev.
REQ-016 On a clk edge where event = 1, the block loads sync_bus <= unsync_bus, sets enable_pulse <= 1, and sets event_cnt <= event_cnt + 1.
REQ-017 On a clk edge where event = 0, sync_bus and event_cnt hold their values and enable_pulse <= 0.
REQ-018 Latency: a bus_enable transition sampled at edge 1 produces enable_pulse = 1 in the cycle after edge NUM_STAGES+1, together with the new sync_bus value.
REQ-019 enable_pulse is exactly one clk cycle wide per event and is never asserted on two consecutive cycles.
REQ-020 event_cnt increments modulo 2^CNT_WIDTH; from all-ones it wraps to 0 with no flag.
REQ-021 unsync_bus is sampled only on an event edge; it is never passed through a synchroniser chain.
REQ-022 Source-side contract: unsync_bus is stable from the bus_enable transition until the sink pulse.
REQ-023 Source-side contract: bus_enable holds each level for at least NUM_STAGES+1 clk periods.
REQ-024 If bus_enable changes faster than REQ-023 allows, the block raises no error; events may merge, and event_cnt counts only the detected events.
REQ-025 In EDGE_MODE 0, a held-high bus_enable produces one event only; a falling edge produces none.
REQ-026 An out-of-range NUM_STAGES (<2 or >4) is rejected at elaboration.

Reset
REQ-027 On a clk edge with rst = 0, the block clears all s[] flops, prev, sync_bus, enable_pulse and event_cnt to 0; this overrides any simultaneous event.
REQ-028 A reset applied mid-chain discards any in-flight event; no pulse follows reset release.
REQ-029 After reset release, a bus_enable that was already high reaches s[NUM_STAGES-1] and, in either mode, causes one event.

Verification
REQ-030 Scenario, EDGE_MODE 0, NUM_STAGES 2: bus = 0xA5, enable rises and is sampled at edge 1 -> enable_pulse = 1 for exactly one cycle after edge 3, sync_bus = 0xA5, event_cnt = 1.
REQ-031 Scenario, EDGE_MODE 0: enable held high for 20 cycles and then falls -> exactly one pulse; sync_bus is unchanged after the fall.
REQ-032 Scenario, EDGE_MODE 1, NUM_STAGES 3: enable toggles 0->1 carrying 0x11, then 1->0 carrying 0x22, 10 cycles apart -> two pulses, each 4 cycles after its edge; sync_bus becomes 0x11 then 0x22; event_cnt = 2.
REQ-033 Scenario, CNT_WIDTH 4: 17 legal events -> event_cnt reads 15 after the 16th event... correction: event_cnt reads 0 after the 16th event and 1 after the 17th.
REQ-034 Scenario: rst = 0 asserted one cycle after enable is sampled (chain partially filled) -> all outputs read 0, and no pulse occurs after reset release while enable is low.
REQ-035 Scenario: unsync_bus changes every cycle while enable is stable -> sync_bus and enable_pulse do not change.

Source files
------------

// File: rtl/bus_sync.sv
// Carries a multi-bit bus into the clk domain by synchronising only its enable
// qualifier; the bus itself is captured once the synchronised enable shows an event.
module bus_sync #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int EDGE_MODE  = 0,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic [CNT_WIDTH-1:0] event_cnt
);

  if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
    $error("bus_sync: NUM_STAGES must be in 2..4");
  end

  logic [NUM_STAGES-1:0] en_sync;
  logic                  en_prev;
  logic                  en_last;
  logic                  event_hit;

  assign en_last = en_sync[NUM_STAGES-1];

  // Rising-edge detect in level mode; any change of level is an event in toggle mode.
  assign event_hit = (EDGE_MODE == 1) ? (en_last ^ en_prev) : (en_last & ~en_prev);

  // Reset wins over a simultaneous event, so an in-flight enable is discarded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_sync      <= '0;
      en_prev      <= 1'b0;
      sync_bus     <= '0;
      enable_pulse <= 1'b0;
      event_cnt    <= '0;
    end else begin
      en_sync      <= {en_sync[NUM_STAGES-2:0], bus_enable};
      en_prev      <= en_last;
      enable_pulse <= event_hit;
      if (event_hit) begin
        sync_bus  <= unsync_bus;
        event_cnt <= event_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_sync.sv
// Directed bench: level-mode instance (2 stages) and toggle-mode instance (3 stages)
// driven in one linear sequence with hand-computed expectations.
module tb_bus_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_a, bus_b;
  logic       en_a, en_b;
  logic [7:0] sync_a, sync_b;
  logic       pulse_a, pulse_b;
  logic [3:0] cnt_a, cnt_b;

  int vectors = 0;
  int errors  = 0;
  int npulse_a = 0;
  int base_pulses;

  always #5 clk = ~clk;

  bus_sync #(.BUS_WIDTH(8), .NUM_STAGES(2), .EDGE_MODE(0), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .unsync_bus(bus_a), .bus_enable(en_a),
    .sync_bus(sync_a), .enable_pulse(pulse_a), .event_cnt(cnt_a)
  );

  bus_sync #(.BUS_WIDTH(8), .NUM_STAGES(3), .EDGE_MODE(1), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .unsync_bus(bus_b), .bus_enable(en_b),
    .sync_bus(sync_b), .enable_pulse(pulse_b), .event_cnt(cnt_b)
  );

  always @(posedge clk) begin
    if (pulse_a === 1'b1) npulse_a <= npulse_a + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0; bus_a = 8'h00; bus_b = 8'h00;
    tick(2);
    chk("rst_sync_a", {8'h0, sync_a}, 16'h0);
    chk("rst_pulse_a", {15'h0, pulse_a}, 16'h0);
    chk("rst_cnt_a", {12'h0, cnt_a}, 16'h0);
    chk("rst_sync_b", {8'h0, sync_b}, 16'h0);
    chk("rst_cnt_b", {12'h0, cnt_b}, 16'h0);
    rst = 1'b1;
    tick(2);

    // Level mode, 2 stages: rise sampled at edge 1, pulse after edge 3.
    bus_a = 8'hA5; en_a = 1'b1;
    tick(2);
    chk("lat_early_pulse", {15'h0, pulse_a}, 16'h0);
    tick(1);
    chk("lat_pulse", {15'h0, pulse_a}, 16'h1);
    chk("lat_sync", {8'h0, sync_a}, 16'h00A5);
    chk("lat_cnt", {12'h0, cnt_a}, 16'h1);
    tick(1);
    chk("pulse_width", {15'h0, pulse_a}, 16'h0);

    // Bus churns while enable is held high: nothing moves.
    for (int i = 0; i < 16; i++) begin
      bus_a = 8'(i * 7 + 3);
      tick(1);
      chk("churn_sync", {8'h0, sync_a}, 16'h00A5);
      chk("churn_pulse", {15'h0, pulse_a}, 16'h0);
    end
    en_a = 1'b0;
    tick(5);
    chk("held_one_pulse", 16'(npulse_a), 16'h1);
    chk("fall_sync", {8'h0, sync_a}, 16'h00A5);
    chk("fall_cnt", {12'h0, cnt_a}, 16'h1);

    // Events 2..17 walk the counter through its wrap.
    for (int k = 2; k <= 17; k++) begin
      bus_a = 8'(k); en_a = 1'b1;
      tick(3);
      chk("wrap_pulse", {15'h0, pulse_a}, 16'h1);
      chk("wrap_sync", {8'h0, sync_a}, 16'(k));
      chk("wrap_cnt", {12'h0, cnt_a}, 16'(k % 16));
      en_a = 1'b0;
      tick(3);
    end
    chk("wrap_total_pulses", 16'(npulse_a), 16'd17);

    // Reset one cycle after the enable is sampled discards it.
    base_pulses = npulse_a;
    bus_a = 8'h5A; en_a = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("midrst_sync", {8'h0, sync_a}, 16'h0);
    chk("midrst_pulse", {15'h0, pulse_a}, 16'h0);
    chk("midrst_cnt", {12'h0, cnt_a}, 16'h0);
    en_a = 1'b0; rst = 1'b1;
    tick(5);
    chk("midrst_no_pulse", 16'(npulse_a - base_pulses), 16'h0);
    chk("midrst_cnt_after", {12'h0, cnt_a}, 16'h0);

    // Enable already high across reset release gives exactly one event.
    rst = 1'b0; en_a = 1'b1; bus_a = 8'h3C;
    tick(2);
    base_pulses = npulse_a;
    rst = 1'b1;
    tick(2);
    chk("rel_early", {15'h0, pulse_a}, 16'h0);
    tick(1);
    chk("rel_pulse", {15'h0, pulse_a}, 16'h1);
    chk("rel_sync", {8'h0, sync_a}, 16'h003C);
    chk("rel_cnt", {12'h0, cnt_a}, 16'h1);
    tick(6);
    chk("rel_single", 16'(npulse_a - base_pulses), 16'h1);

    // Toggle mode, 3 stages: each edge is an event, pulse after edge 4.
    bus_b = 8'h11; en_b = 1'b1;
    tick(3);
    chk("tog_r_early", {15'h0, pulse_b}, 16'h0);
    tick(1);
    chk("tog_r_pulse", {15'h0, pulse_b}, 16'h1);
    chk("tog_r_sync", {8'h0, sync_b}, 16'h0011);
    chk("tog_r_cnt", {12'h0, cnt_b}, 16'h1);
    tick(6);
    bus_b = 8'h22; en_b = 1'b0;
    tick(3);
    chk("tog_f_early", {15'h0, pulse_b}, 16'h0);
    chk("tog_f_hold", {8'h0, sync_b}, 16'h0011);
    tick(1);
    chk("tog_f_pulse", {15'h0, pulse_b}, 16'h1);
    chk("tog_f_sync", {8'h0, sync_b}, 16'h0022);
    chk("tog_f_cnt", {12'h0, cnt_b}, 16'h2);
    tick(1);
    chk("tog_f_width", {15'h0, pulse_b}, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
